// File: rtl/exchange_bank_if.sv
// Bundle of the fill, stream, swap and readback signals of one replica's route store.
// Latency: none (wiring only).
// Backpressure: none; the master owns requests and the slave owns status/results.
interface exchange_bank_if #(
  parameter int CITY_NUM = 64,
  parameter int CPW      = 8,
  parameter int SRC_NUM  = 3
);
  localparam int CITY_LOG = $clog2(CITY_NUM);
  localparam int SW       = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
  localparam int WW       = CPW * CITY_LOG;

  logic                    fill_start;
  logic [SW-1:0]           src_sel;
  logic [SRC_NUM-1:0]      in_valid;
  logic [SRC_NUM*WW-1:0]   in_data;
  logic                    fill_busy;
  logic                    fill_done;
  logic                    rd_start;
  logic                    out_valid;
  logic [WW-1:0]           out_data;
  logic                    out_last;
  logic                    swap;
  logic                    swap_pend;
  logic                    rbank;
  logic                    ord_req;
  logic [CITY_LOG-1:0]     ord_addr;
  logic                    ord_valid;
  logic [CITY_LOG-1:0]     ord_data;
  logic                    err;

  modport master (
    output fill_start, src_sel, in_valid, in_data, rd_start, swap, ord_req, ord_addr,
    input  fill_busy, fill_done, out_valid, out_data, out_last, swap_pend, rbank,
           ord_valid, ord_data, err
  );

  modport slave (
    input  fill_start, src_sel, in_valid, in_data, rd_start, swap, ord_req, ord_addr,
    output fill_busy, fill_done, out_valid, out_data, out_last, swap_pend, rbank,
           ord_valid, ord_data, err
  );
endinterface

// File: rtl/exchange_bank.sv
// Double-buffered route store: neighbour fill into one bank, streaming/readback from the other.
// Latency: stream word n at rd_start+2+n; single-city readback 2 cycles after ord_req.
// Backpressure: none; fill advances only on the chosen source's valid, conflicting requests set err.
module exchange_bank #(
  parameter int CITY_NUM = 64,
  parameter int CPW      = 8,
  parameter int SRC_NUM  = 3
) (
  input  logic            clk,
  input  logic            reset,
  exchange_bank_if.slave  bus
);
  localparam int CITY_LOG = $clog2(CITY_NUM);
  localparam int WORDS    = CITY_NUM / CPW;
  localparam int CW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LW       = (CPW > 1) ? $clog2(CPW) : 1;
  localparam int SW       = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
  localparam int WW       = CPW * CITY_LOG;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic {F_IDLE, F_FILL} fill_st_e;
  typedef enum logic {R_IDLE, R_READ} rd_st_e;

  // Both banks in one array, addressed {bank, word}.
  logic [WW-1:0] mem [2*WORDS];
  logic [WW-1:0] rdat_q, odat_q;

  fill_st_e            fill_st_q, fill_st_d;
  rd_st_e              rd_st_q, rd_st_d;
  logic [SW-1:0]       src_q, src_d;
  logic [CW-1:0]       wcount_q, wcount_d;
  logic [CW-1:0]       rcount_q, rcount_d;
  logic                fill_done_q, fill_done_d;
  logic                rbank_q, rbank_d;
  logic                swap_pend_q, swap_pend_d;
  logic                err_q, err_d;
  logic                rvld_q, rvld_d;
  logic                rlast_q, rlast_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [WW-1:0]       out_data_q, out_data_d;
  logic                ovld_q, ovld_d;
  logic [LW-1:0]       olane_q, olane_d;
  logic                ord_valid_q, ord_valid_d;
  logic [CITY_LOG-1:0] ord_data_q, ord_data_d;

  logic                wr_en, rd_en, rd_is_last, ord_en;
  logic                fill_err, rd_err, ord_err;
  logic [CW-1:0]       rd_word;
  logic [WW-1:0]       wr_dat;
  logic                both_idle;

  // Fill FSM: accept the selected source's words into the bank opposite the read bank.
  always_comb begin
    fill_st_d   = fill_st_q;
    src_d       = src_q;
    wcount_d    = wcount_q;
    fill_done_d = 1'b0;
    fill_err    = 1'b0;
    wr_en       = 1'b0;
    wr_dat      = bus.in_data[src_q*WW +: WW];
    case (fill_st_q)
      F_IDLE: begin
        if (bus.fill_start) begin
          if (32'(bus.src_sel) >= SRC_NUM) begin
            fill_err = 1'b1;
          end else begin
            src_d     = bus.src_sel;
            wcount_d  = '0;
            fill_st_d = F_FILL;
          end
        end
      end
      F_FILL: begin
        if (bus.fill_start) fill_err = 1'b1;
        if (bus.in_valid[src_q]) begin
          wr_en = 1'b1;
          if (wcount_q == LAST) begin
            wcount_d    = '0;
            fill_st_d   = F_IDLE;
            fill_done_d = 1'b1;
          end else begin
            wcount_d = wcount_q + 1'b1;
          end
        end
      end
      default: fill_st_d = F_IDLE;
    endcase
  end

  // Read FSM: word 0 is fetched in the rd_start cycle itself so the stream lands at +2.
  always_comb begin
    rd_st_d    = rd_st_q;
    rcount_d   = rcount_q;
    rd_en      = 1'b0;
    rd_word    = rcount_q;
    rd_is_last = 1'b0;
    rd_err     = 1'b0;
    case (rd_st_q)
      R_IDLE: begin
        if (bus.rd_start) begin
          rd_en   = 1'b1;
          rd_word = '0;
          if (LAST == '0) begin
            rd_is_last = 1'b1;
          end else begin
            rcount_d = CW'(1);
            rd_st_d  = R_READ;
          end
        end
      end
      R_READ: begin
        rd_en = 1'b1;
        if (bus.rd_start) rd_err = 1'b1;
        if (rcount_q == LAST) begin
          rd_is_last = 1'b1;
          rcount_d   = '0;
          rd_st_d    = R_IDLE;
        end else begin
          rcount_d = rcount_q + 1'b1;
        end
      end
      default: rd_st_d = R_IDLE;
    endcase
  end

  // Bank swap: immediate when both FSMs idle, otherwise held pending until they are.
  always_comb begin
    both_idle   = (fill_st_q == F_IDLE) && (rd_st_q == R_IDLE);
    rbank_d     = rbank_q;
    swap_pend_d = swap_pend_q;
    if (both_idle && (bus.swap || swap_pend_q)) begin
      rbank_d     = ~rbank_q;
      swap_pend_d = 1'b0;
    end else if (bus.swap) begin
      swap_pend_d = 1'b1;
    end
  end

  // Readback acceptance, output pipelines and sticky error.
  always_comb begin
    ord_en      = bus.ord_req && (rd_st_q == R_IDLE) && !bus.rd_start;
    ord_err     = bus.ord_req && !ord_en;
    rvld_d      = rd_en;
    rlast_d     = rd_is_last;
    out_valid_d = rvld_q;
    out_last_d  = rvld_q & rlast_q;
    out_data_d  = rvld_q ? rdat_q : out_data_q;
    ovld_d      = ord_en;
    olane_d     = ord_en ? bus.ord_addr[LW-1:0] : olane_q;
    ord_valid_d = ovld_q;
    ord_data_d  = ord_data_q;
    if (ovld_q) begin
      for (int k = 0; k < CPW; k++) begin
        if (olane_q == LW'(k)) ord_data_d = odat_q[k*CITY_LOG +: CITY_LOG];
      end
    end
    err_d = err_q | fill_err | rd_err | ord_err;
  end

  // RAM: one write port, stream read port and readback read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en)  mem[{~rbank_q, wcount_q}] <= wr_dat;
    if (rd_en)  rdat_q <= mem[{rbank_d, rd_word}];
    if (ord_en) odat_q <= mem[{rbank_q, bus.ord_addr[CITY_LOG-1:LW]}];
  end

  // Control and output state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_st_q   <= F_IDLE;
      rd_st_q     <= R_IDLE;
      src_q       <= '0;
      wcount_q    <= '0;
      rcount_q    <= '0;
      fill_done_q <= 1'b0;
      rbank_q     <= 1'b0;
      swap_pend_q <= 1'b0;
      err_q       <= 1'b0;
      rvld_q      <= 1'b0;
      rlast_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      ovld_q      <= 1'b0;
      olane_q     <= '0;
      ord_valid_q <= 1'b0;
      ord_data_q  <= '0;
    end else begin
      fill_st_q   <= fill_st_d;
      rd_st_q     <= rd_st_d;
      src_q       <= src_d;
      wcount_q    <= wcount_d;
      rcount_q    <= rcount_d;
      fill_done_q <= fill_done_d;
      rbank_q     <= rbank_d;
      swap_pend_q <= swap_pend_d;
      err_q       <= err_d;
      rvld_q      <= rvld_d;
      rlast_q     <= rlast_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      ovld_q      <= ovld_d;
      olane_q     <= olane_d;
      ord_valid_q <= ord_valid_d;
      ord_data_q  <= ord_data_d;
    end
  end

  assign bus.fill_busy = (fill_st_q == F_FILL);
  assign bus.fill_done = fill_done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.swap_pend = swap_pend_q;
  assign bus.rbank     = rbank_q;
  assign bus.ord_valid = ord_valid_q;
  assign bus.ord_data  = ord_data_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_exchange_bank.sv
// Randomised bench for exchange_bank with a city-array reference model and scoreboard queues.
// Latency: checks stream beats at rd_start+2+n and readback at ord_req+2.
// Backpressure: none exercised; the monitor pops an expectation for every valid output.
module tb_exchange_bank;
  localparam int CITY_NUM = 64;
  localparam int CPW      = 8;
  localparam int SRC_NUM  = 3;
  localparam int CL       = 6;
  localparam int WORDS    = 8;
  localparam int WW       = CPW * CL;

  typedef struct {
    logic [WW-1:0] data;
    logic          last;
    int            cyc;
  } beat_t;

  typedef struct {
    logic [CL-1:0] data;
    int            cyc;
  } ord_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exchange_bank_if #(.CITY_NUM(CITY_NUM), .CPW(CPW), .SRC_NUM(SRC_NUM)) bus ();

  exchange_bank #(.CITY_NUM(CITY_NUM), .CPW(CPW), .SRC_NUM(SRC_NUM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int m_rbank = 0;
  logic [CL-1:0] mdl [2][CITY_NUM];
  beat_t exp_out[$];
  ord_t  exp_ord[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] pack_word(input int b, input int w);
    logic [WW-1:0] r;
    r = '0;
    for (int k = 0; k < CPW; k++) r[k*CL +: CL] = mdl[b][w*CPW + k];
    return r;
  endfunction

  function automatic logic [SRC_NUM*WW-1:0] rand_data();
    logic [SRC_NUM*WW-1:0] r;
    for (int i = 0; i < SRC_NUM*WW; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Queue the full stream of the current read bank; call in the rd_start cycle.
  task automatic push_read();
    beat_t e;
    for (int n = 0; n < WORDS; n++) begin
      e.data = pack_word(m_rbank, n);
      e.last = (n == WORDS - 1);
      e.cyc  = cyc + 2 + n;
      exp_out.push_back(e);
    end
  endtask

  // Fill nwords words from src with random gaps and junk on other sources;
  // swap is pulsed alongside the writes of words sw1 and sw2.
  task automatic do_fill(input int src, input int nwords, input bit ident,
                         input int sw1, input int sw2);
    int wb, d0, last_wr;
    logic [WW-1:0] word;
    logic [SRC_NUM*WW-1:0] dat;
    wb = 1 - m_rbank;
    d0 = done_cnt;
    last_wr = -1;
    bus.fill_start = 1'b1;
    bus.src_sel = 2'(src);
    step();
    bus.fill_start = 1'b0;
    bus.rd_start = 1'b0;
    for (int w = 0; w < nwords; w++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 3'($urandom) & ~(3'b001 << src);
        bus.in_data = rand_data();
        step();
      end
      for (int k = 0; k < CPW; k++) begin
        word[k*CL +: CL] = ident ? 6'(w*CPW + k) : 6'($urandom_range(0, 63));
        mdl[wb][w*CPW + k] = word[k*CL +: CL];
      end
      dat = rand_data();
      dat[src*WW +: WW] = word;
      bus.in_data = dat;
      bus.in_valid = 3'($urandom) | (3'b001 << src);
      bus.swap = (w == sw1) || (w == sw2);
      step();
      last_wr = cyc - 1;
      if (bus.swap) begin
        chk("swap_pend_while_busy", 64'(bus.swap_pend), 64'd1);
        chk("rbank_held_while_busy", 64'(bus.rbank), 64'(m_rbank));
      end
      bus.swap = 1'b0;
    end
    bus.in_valid = '0;
    if (nwords == WORDS) begin
      step();
      step();
      chk("fill_done_count", 64'(done_cnt - d0), 64'd1);
      chk("fill_done_timing", 64'(done_cyc), 64'(last_wr + 1));
      chk("fill_busy_after", 64'(bus.fill_busy), 64'd0);
    end
  endtask

  task automatic idle_swap();
    bus.swap = 1'b1;
    step();
    bus.swap = 1'b0;
    chk("rbank_after_swap", 64'(bus.rbank), 64'(m_rbank ^ 1));
    chk("swap_pend_idle", 64'(bus.swap_pend), 64'd0);
    m_rbank ^= 1;
  endtask

  task automatic stream();
    bus.rd_start = 1'b1;
    push_read();
    step();
    bus.rd_start = 1'b0;
    repeat (WORDS + 3) step();
  endtask

  // Monitor: every valid output pops the oldest expectation of its stream.
  always @(negedge clk) begin
    if (bus.fill_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.out_valid) begin
      if (exp_out.size() == 0) begin
        chk("out_spurious_beat", 64'(bus.out_valid), 64'd0);
      end else begin
        beat_t e;
        e = exp_out.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(e.data));
        chk("out_last", 64'(bus.out_last), 64'(e.last));
        chk("out_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (bus.ord_valid) begin
      if (exp_ord.size() == 0) begin
        chk("ord_spurious", 64'(bus.ord_valid), 64'd0);
      end else begin
        ord_t o;
        o = exp_ord.pop_front();
        chk("ord_data", 64'(bus.ord_data), 64'(o.data));
        chk("ord_cycle", 64'(cyc), 64'(o.cyc));
      end
    end
  end

  initial begin
    int rb0, d0;
    ord_t o;
    reset = 1'b1;
    bus.fill_start = 1'b0;
    bus.src_sel = '0;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.rd_start = 1'b0;
    bus.swap = 1'b0;
    bus.ord_req = 1'b0;
    bus.ord_addr = '0;
    step();
    step();
    chk("rst_fill_busy", 64'(bus.fill_busy), 64'd0);
    chk("rst_fill_done", 64'(bus.fill_done), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_swap_pend", 64'(bus.swap_pend), 64'd0);
    chk("rst_rbank", 64'(bus.rbank), 64'd0);
    chk("rst_ord_valid", 64'(bus.ord_valid), 64'd0);
    chk("rst_ord_data", 64'(bus.ord_data), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    reset = 1'b0;
    step();

    // Fill from source 2 into bank 1, swap, stream it back.
    do_fill(2, WORDS, 1'b0, -1, -1);
    idle_swap();
    stream();

    // Stream bank 1 while filling bank 0; swaps during the overlap are deferred and merged.
    rb0 = m_rbank;
    bus.rd_start = 1'b1;
    push_read();
    do_fill(1, WORDS, 1'b0, 1, 4);
    chk("overlap_single_toggle", 64'(bus.rbank), 64'(rb0 ^ 1));
    chk("overlap_pend_cleared", 64'(bus.swap_pend), 64'd0);
    m_rbank ^= 1;
    stream();

    // Identity route, then back-to-back single-city readback.
    do_fill(0, WORDS, 1'b1, -1, -1);
    idle_swap();
    for (int a = 0; a < CITY_NUM; a++) begin
      bus.ord_req = 1'b1;
      bus.ord_addr = 6'(a);
      o.data = mdl[m_rbank][a];
      o.cyc = cyc + 2;
      exp_ord.push_back(o);
      step();
    end
    bus.ord_req = 1'b0;
    repeat (3) step();
    chk("err_before_conflict", 64'(bus.err), 64'd0);
    bus.ord_req = 1'b1;
    bus.ord_addr = 6'd5;
    bus.rd_start = 1'b1;
    push_read();
    step();
    bus.ord_req = 1'b0;
    bus.rd_start = 1'b0;
    repeat (WORDS + 3) step();
    chk("err_ord_conflict", 64'(bus.err), 64'd1);

    // Reset in the middle of a fill: no done pulse, state back to reset values.
    d0 = done_cnt;
    do_fill(2, 4, 1'b0, -1, -1);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    m_rbank = 0;
    step();
    chk("midfill_no_done", 64'(done_cnt - d0), 64'd0);
    chk("midfill_busy", 64'(bus.fill_busy), 64'd0);
    chk("midfill_rbank", 64'(bus.rbank), 64'd0);
    chk("midfill_err", 64'(bus.err), 64'd0);
    do_fill(1, WORDS, 1'b0, -1, -1);
    idle_swap();
    stream();

    // Illegal requests: bad source and rd_start during a stream.
    bus.fill_start = 1'b1;
    bus.src_sel = 2'd3;
    step();
    bus.fill_start = 1'b0;
    chk("bad_src_no_fill", 64'(bus.fill_busy), 64'd0);
    chk("bad_src_err", 64'(bus.err), 64'd1);
    bus.rd_start = 1'b1;
    push_read();
    step();
    bus.rd_start = 1'b0;
    step();
    bus.rd_start = 1'b1;
    step();
    bus.rd_start = 1'b0;
    repeat (WORDS + 3) step();
    chk("err_sticky", 64'(bus.err), 64'd1);

    chk("out_queue_drained", 64'(exp_out.size()), 64'd0);
    chk("ord_queue_drained", 64'(exp_ord.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
